cpu6_csr_ctrl: RTL and testbench

Initiator side of the CSR access interface. Executes Zicsr instructions (CSRRW/S/C and immediate forms) handed over by the execute stage. Issues read and write strobes to the CSR register file, performs the read-modify-write, and returns the old CSR value for rd writeback. Sits between the execute stage and cpu6_csr.

---
 rtl/cpu6_csr_ctrl_pkg.sv | 37 +++
 rtl/cpu6_csr_ctrl_alu.sv | 27 ++
 rtl/cpu6_csr_ctrl.sv | 112 +++++++++++
 tb/tb_cpu6_csr_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6_csr_ctrl_pkg.sv
// cpu6_csr_ctrl_pkg: shared definitions for the CSR access initiator.
//   - default datapath and CSR index widths
//   - Zicsr funct3 encodings, the ALU op type, and the controller FSM states
package cpu6_csr_ctrl_pkg;

  localparam int CPU6_XLEN     = 32;
  localparam int CPU6_CSR_SIZE = 12;

  // Zicsr funct3 encodings. The immediate forms set bit 2.
  localparam logic [2:0] CPU6_CSR_RW  = 3'b001;
  localparam logic [2:0] CPU6_CSR_RS  = 3'b010;
  localparam logic [2:0] CPU6_CSR_RC  = 3'b011;
  localparam logic [2:0] CPU6_CSR_RWI = 3'b101;
  localparam logic [2:0] CPU6_CSR_RSI = 3'b110;
  localparam logic [2:0] CPU6_CSR_RCI = 3'b111;

  // The low two funct3 bits select the operation. 00 is reserved.
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

  typedef enum logic [2:0] {
    CPU6_CSRC_IDLE  = 3'd0,
    CPU6_CSRC_READ  = 3'd1,
    CPU6_CSRC_WRITE = 3'd2,
    CPU6_CSRC_RESP  = 3'd3,
    CPU6_CSRC_ERR   = 3'd4
  } csrc_state_t;

  function automatic csr_op_t csr_op_of(input logic [2:0] funct3);
    return csr_op_t'(funct3[1:0]);
  endfunction

endpackage

// File: rtl/cpu6_csr_ctrl_alu.sv
// cpu6_csr_ctrl_alu: combinational read-modify-write for Zicsr.
//   op      in  csr operation (RW / RS / RC)
//   old_val in  CSR value read in the READ cycle
//   src     in  rs1 value or zero-extended zimm
//   new_val out value to write back
module cpu6_csr_ctrl_alu
  import cpu6_csr_ctrl_pkg::*;
#(
  parameter int XLEN = CPU6_XLEN
) (
  input  csr_op_t         op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src,
  output logic [XLEN-1:0] new_val
);

  always_comb begin
    new_val = '0;
    case (op)
      CSR_OP_RW: new_val = src;
      CSR_OP_RS: new_val = old_val | src;
      CSR_OP_RC: new_val = old_val & ~src;
      default:   new_val = '0;
    endcase
  end

endmodule

// File: rtl/cpu6_csr_ctrl.sv
// cpu6_csr_ctrl: initiator side of the CSR access interface.
// Takes one Zicsr instruction from execute, reads the CSR, writes the
// modified value and returns the old value for rd writeback.
//   clk, reset               clock, synchronous active-high reset
//   ex_valid/ex_ready        instruction handshake from execute
//   ex_funct3/csr_idx/rs1_*  instruction fields and rs1 value
//   ex_rd_idx                destination register
//   flush                    kill in-flight instruction
//   csr_rd_en/csr_wr_en      strobes to CSR file, csr_idx/csr_write_dat
//   csr_read_dat             combinational read data from CSR file
//   wb_valid/wb_rd_idx/wb_dat writeback of old CSR value
//   illegal                  reserved funct3 pulse
module cpu6_csr_ctrl
  import cpu6_csr_ctrl_pkg::*;
#(
  parameter int XLEN   = CPU6_XLEN,
  parameter int CSR_AW = CPU6_CSR_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [2:0]        ex_funct3,
  input  logic [CSR_AW-1:0] ex_csr_idx,
  input  logic [4:0]        ex_rs1_idx,
  input  logic [XLEN-1:0]   ex_rs1_dat,
  input  logic [4:0]        ex_rd_idx,
  input  logic              flush,
  output logic              csr_rd_en,
  output logic              csr_wr_en,
  output logic [CSR_AW-1:0] csr_idx,
  input  logic [XLEN-1:0]   csr_read_dat,
  output logic [XLEN-1:0]   csr_write_dat,
  output logic              wb_valid,
  output logic [4:0]        wb_rd_idx,
  output logic [XLEN-1:0]   wb_dat,
  output logic              illegal
);

  csrc_state_t       state;
  csr_op_t           op_r;
  logic [CSR_AW-1:0] idx_r;
  logic [4:0]        rd_r;
  logic [4:0]        fld_r;   // rs1 index or zimm; drives the write decision
  logic [XLEN-1:0]   src_r;
  logic [XLEN-1:0]   old_r;
  logic [XLEN-1:0]   alu_out;

  logic accept, is_rw, do_rd, do_wr;

  assign ex_ready = (state == CPU6_CSRC_IDLE) & ~flush & ~reset;
  assign accept   = ex_valid & ex_ready;

  assign is_rw = (op_r == CSR_OP_RW);
  assign do_rd = ~(is_rw & (rd_r == 5'd0));
  // Tested on the field, not the register value: CSRRS with a nonzero
  // rs1 that holds zero still writes.
  assign do_wr = is_rw | (fld_r != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CPU6_CSRC_IDLE;
      op_r  <= CSR_OP_NONE;
      idx_r <= '0;
      rd_r  <= '0;
      fld_r <= '0;
      src_r <= '0;
      old_r <= '0;
    end else begin
      case (state)
        CPU6_CSRC_IDLE: if (accept) begin
          op_r  <= csr_op_of(ex_funct3);
          idx_r <= ex_csr_idx;
          rd_r  <= ex_rd_idx;
          fld_r <= ex_rs1_idx;
          src_r <= ex_funct3[2] ? {{(XLEN-5){1'b0}}, ex_rs1_idx} : ex_rs1_dat;
          state <= (ex_funct3[1:0] == 2'b00) ? CPU6_CSRC_ERR : CPU6_CSRC_READ;
        end
        CPU6_CSRC_READ: begin
          old_r <= do_rd ? csr_read_dat : '0;
          state <= flush ? CPU6_CSRC_IDLE : CPU6_CSRC_WRITE;
        end
        CPU6_CSRC_WRITE: state <= flush ? CPU6_CSRC_IDLE : CPU6_CSRC_RESP;
        CPU6_CSRC_RESP:  state <= CPU6_CSRC_IDLE;
        CPU6_CSRC_ERR:   state <= CPU6_CSRC_IDLE;
        default:         state <= CPU6_CSRC_IDLE;
      endcase
    end
  end

  cpu6_csr_ctrl_alu #(.XLEN(XLEN)) u_alu (
    .op      (op_r),
    .old_val (old_r),
    .src     (src_r),
    .new_val (alu_out)
  );

  // Strobes decode from the registered state. flush gates the write so the
  // exception that raised it owns the CSR file that cycle; reset gates
  // everything so no partial access survives once reset is seen.
  always_comb begin
    csr_rd_en     = (state == CPU6_CSRC_READ) & do_rd & ~reset;
    csr_wr_en     = (state == CPU6_CSRC_WRITE) & do_wr & ~flush & ~reset;
    csr_idx       = (csr_rd_en | csr_wr_en) ? idx_r : '0;
    csr_write_dat = csr_wr_en ? alu_out : '0;
    wb_valid      = (state == CPU6_CSRC_RESP) & (rd_r != 5'd0) & ~flush & ~reset;
    wb_rd_idx     = wb_valid ? rd_r : '0;
    wb_dat        = wb_valid ? old_r : '0;
    illegal       = (state == CPU6_CSRC_ERR) & ~reset;
  end

endmodule

// File: tb/tb_cpu6_csr_ctrl.sv
// tb_cpu6_csr_ctrl: directed plus randomized Zicsr traffic against a
// behavioural model of instruction results and CSR contents.
module tb_cpu6_csr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready;
  logic [2:0]  ex_funct3;
  logic [11:0] ex_csr_idx;
  logic [4:0]  ex_rs1_idx, ex_rd_idx;
  logic [31:0] ex_rs1_dat;
  logic        flush;
  logic        csr_rd_en, csr_wr_en;
  logic [11:0] csr_idx;
  logic [31:0] csr_read_dat, csr_write_dat;
  logic        wb_valid;
  logic [4:0]  wb_rd_idx;
  logic [31:0] wb_dat;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  localparam logic [11:0] MEPC = 12'h341;
  localparam logic [11:0] MSCR = 12'h340;
  localparam logic [11:0] MTVC = 12'h305;

  always #5 clk = ~clk;

  cpu6_csr_ctrl dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_funct3(ex_funct3),
    .ex_csr_idx(ex_csr_idx), .ex_rs1_idx(ex_rs1_idx), .ex_rs1_dat(ex_rs1_dat),
    .ex_rd_idx(ex_rd_idx), .flush(flush),
    .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_idx(csr_idx),
    .csr_read_dat(csr_read_dat), .csr_write_dat(csr_write_dat),
    .wb_valid(wb_valid), .wb_rd_idx(wb_rd_idx), .wb_dat(wb_dat),
    .illegal(illegal)
  );

  // CSR file seen by the DUT: combinational read, mepc bit0 hardwired 0.
  logic [31:0] env_csr [4096];
  assign csr_read_dat = csr_rd_en ? env_csr[csr_idx] : 32'h0;
  always @(posedge clk)
    if (csr_wr_en) env_csr[csr_idx] <= (csr_idx == MEPC) ? (csr_write_dat & ~32'h1) : csr_write_dat;

  // Reference CSR contents, updated only from the model's own decisions.
  logic [31:0] ref_csr [4096];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
    env_csr[a] = v;
    ref_csr[a] = v;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_funct3 = 0; ex_csr_idx = 0; ex_rs1_idx = 0;
    ex_rs1_dat = 0; ex_rd_idx = 0; flush = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd"}, csr_rd_en, 0);
    chk({tag, "_wr"}, csr_wr_en, 0);
    chk({tag, "_wb"}, wb_valid, 0);
    chk({tag, "_ill"}, illegal, 0);
    chk({tag, "_idx"}, csr_idx, 0);
    chk({tag, "_wd"}, csr_write_dat, 0);
  endtask

  // Run one instruction. flush_at: 0 none, 1..3 = cycle after accept.
  task automatic run_op(input logic [2:0] f3, input logic [11:0] a,
                        input logic [4:0] rs1, input logic [31:0] rs1v,
                        input logic [4:0] rd, input int flush_at);
    logic [31:0] src, old, nv;
    bit rsv, rw, rdo, wro;
    rsv = (f3 == 3'b000) || (f3 == 3'b100);
    rw  = (f3 == 3'b001) || (f3 == 3'b101);
    src = f3[2] ? {27'h0, rs1} : rs1v;
    rdo = !(rw && rd == 0);
    wro = rw || (rs1 != 0);
    old = rdo ? ref_csr[a] : 32'h0;
    case (f3[1:0])
      2'b01:   nv = src;
      2'b10:   nv = ref_csr[a] | src;
      default: nv = ref_csr[a] & ~src;
    endcase

    @(negedge clk);
    ex_valid = 1; ex_funct3 = f3; ex_csr_idx = a; ex_rs1_idx = rs1;
    ex_rs1_dat = rs1v; ex_rd_idx = rd; flush = 0;
    #1 chk("accept_ready", ex_ready, 1);

    @(negedge clk);
    idle_inputs();
    flush = (flush_at == 1);
    #1;
    chk("busy_ready", ex_ready, 0);
    if (rsv) begin
      chk("ill_pulse", illegal, 1);
      chk("ill_rd", csr_rd_en, 0);
      chk("ill_wr", csr_wr_en, 0);
      chk("ill_wb", wb_valid, 0);
      @(negedge clk); flush = 0;
      #1 chk("ill_ready", ex_ready, 1);
      chk("ill_once", illegal, 0);
      return;
    end
    chk("rd_en", csr_rd_en, rdo);
    chk("rd_idx", csr_idx, rdo ? a : 12'h0);
    chk("rd_nowr", csr_wr_en, 0);
    if (flush_at == 1) begin
      @(negedge clk); flush = 0;
      #1 chk("fl1_ready", ex_ready, 1);
      chk_quiet("fl1");
      return;
    end

    @(negedge clk);
    flush = (flush_at == 2);
    #1;
    chk("wr_en", csr_wr_en, wro && flush_at != 2);
    chk("wr_dat", csr_write_dat, (wro && flush_at != 2) ? nv : 32'h0);
    chk("wr_nord", csr_rd_en, 0);
    if (wro && flush_at != 2) ref_csr[a] = (a == MEPC) ? (nv & ~32'h1) : nv;
    if (flush_at == 2) begin
      @(negedge clk); flush = 0;
      #1 chk("fl2_ready", ex_ready, 1);
      chk_quiet("fl2");
      return;
    end

    @(negedge clk);
    flush = (flush_at == 3);
    #1;
    chk("wb_valid", wb_valid, rd != 0 && flush_at != 3);
    if (rd != 0 && flush_at != 3) begin
      chk("wb_rd", wb_rd_idx, rd);
      chk("wb_dat", wb_dat, old);
    end
    chk("wb_nostb", csr_rd_en | csr_wr_en, 0);

    @(negedge clk); flush = 0;
    #1 chk("next_ready", ex_ready, 1);
    chk_quiet("post");
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    for (int i = 0; i < 4096; i++) begin env_csr[i] = 0; ref_csr[i] = 0; end
    repeat (2) @(negedge clk);
    #1 chk("rst_ready", ex_ready, 0);
    chk_quiet("rst");
    chk("rst_wbrd", wb_rd_idx, 0);
    chk("rst_wbdat", wb_dat, 0);
    reset = 0;
    #1 chk("rst_rel_ready", ex_ready, 1);

    // Simple write, then read-back sees bit0 cleared by the CSR file.
    set_csr(MEPC, 32'h0);
    run_op(3'b001, MEPC, 5'd5, 32'h0000_1235, 5'd6, 0);
    run_op(3'b010, MEPC, 5'd0, 32'h0, 5'd8, 0);
    chk("mepc_rb", ref_csr[MEPC], 32'h0000_1234);
    // Set with zero source field: no write, old value returned.
    set_csr(MEPC, 32'h100);
    run_op(3'b010, MEPC, 5'd0, 32'hFFFF_FFFF, 5'd7, 0);
    // Immediate clear.
    set_csr(MEPC, 32'hFC);
    run_op(3'b111, MEPC, 5'h0C, 32'h0, 5'd9, 0);
    chk("rci_val", env_csr[MEPC], 32'hF0);
    // CSRRW to x0: no read, write, no wb.
    run_op(3'b001, MSCR, 5'd3, 32'hDEAD_BEEF, 5'd0, 0);
    // Flush in WRITE: CSR unchanged.
    set_csr(MEPC, 32'h40);
    run_op(3'b001, MEPC, 5'd4, 32'h1234_5678, 5'd2, 2);
    chk("fl_mepc", env_csr[MEPC], 32'h40);
    // Reserved funct3.
    run_op(3'b100, MEPC, 5'd1, 32'h1, 5'd1, 0);
    run_op(3'b000, MTVC, 5'd1, 32'h1, 5'd1, 1);
    // Flush during offer blocks acceptance.
    @(negedge clk);
    ex_valid = 1; ex_funct3 = 3'b001; flush = 1;
    #1 chk("flush_noready", ex_ready, 0);
    @(negedge clk); idle_inputs();
    #1 chk_quiet("flush_offer");

    // Reset at N+1 of a normal op.
    @(negedge clk);
    ex_valid = 1; ex_funct3 = 3'b001; ex_csr_idx = MSCR; ex_rs1_idx = 5'd1;
    ex_rs1_dat = 32'h5555_AAAA; ex_rd_idx = 5'd3;
    @(negedge clk); idle_inputs(); reset = 1;
    #1 chk("rst_mid_rd", csr_rd_en, 0);
    @(negedge clk); reset = 0;
    #1 chk("rst_mid_ready", ex_ready, 1);
    chk_quiet("rst_mid");
    repeat (3) @(negedge clk);
    #1 chk_quiet("rst_mid_after");
    chk("rst_mid_csr", env_csr[MSCR], ref_csr[MSCR]);

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      logic [2:0]  f3;
      logic [11:0] a;
      logic [4:0]  rs1, rd;
      int          fa;
      f3  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: a = MEPC;
        1: a = MSCR;
        default: a = MTVC;
      endcase
      rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      fa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(f3, a, rs1, $urandom, rd, fa);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    chk("end_mepc", env_csr[MEPC], ref_csr[MEPC]);
    chk("end_mscr", env_csr[MSCR], ref_csr[MSCR]);
    chk("end_mtvc", env_csr[MTVC], ref_csr[MTVC]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
